// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and defaults for the memory-stage controller.
package mem_stage_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int CTR_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/dff.sv
// Generic register cell with asynchronous active-low clear to zero.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // Plain storage: zero on reset, otherwise follow d_i every rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_o <= '0;
    else        q_o <= d_i;
  end

endmodule

// File: rtl/mem_timeout_ctr.sv
// Counts WAIT cycles and flags the increment that would reach TIMEOUT.
module mem_timeout_ctr
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CTR_W-1:0] cnt_q, cnt_d;

  // Clear has priority over counting so every new wait starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = en_i & ~clr_i & (cnt_q == CTR_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns an EX_MEM load/store into a single-strobe
// handshake with a multi-cycle data memory and stalls the pipeline meanwhile.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_en,
  input  logic              mem_write_en,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy,
  input  logic              mem_done,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] MemRead_out,
  output logic              stall_out,
  output logic              err_out
);

  state_t            state_q, state_d;
  logic [1:0]        stateRaw_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              isRead_q, isRead_d;
  logic              err_q, err_d;

  logic req, bad, accept;
  logic ctrClr, ctrEn, expired;
  logic stallC;

  assign req    = mem_read_en | mem_write_en;
  assign bad    = req & (addr_in[0] | (mem_read_en & mem_write_en));
  assign accept = req & ~bad & ~err_q;

  dff #(.W(2))      uState  (.clk(clk), .rst_n(rst), .d_i(state_d),  .q_o(stateRaw_q));
  dff #(.W(ADDR_W)) uAddr   (.clk(clk), .rst_n(rst), .d_i(addr_d),   .q_o(addr_q));
  dff #(.W(DATA_W)) uWdata  (.clk(clk), .rst_n(rst), .d_i(wdata_d),  .q_o(wdata_q));
  dff #(.W(DATA_W)) uRdata  (.clk(clk), .rst_n(rst), .d_i(rdata_d),  .q_o(rdata_q));
  dff #(.W(1))      uIsRead (.clk(clk), .rst_n(rst), .d_i(isRead_d), .q_o(isRead_q));
  dff #(.W(1))      uErr    (.clk(clk), .rst_n(rst), .d_i(err_d),    .q_o(err_q));

  assign state_q = state_t'(stateRaw_q);

  // The counter only runs while waiting; any other state resets it.
  assign ctrClr = (state_q != ST_WAIT);

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) uTimeout (
    .clk       (clk),
    .rst_n     (rst),
    .clr_i     (ctrClr),
    .en_i      (ctrEn),
    .expired_o (expired)
  );

  // Next-state, strobe and stall decode for the access handshake.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    isRead_d = isRead_q;
    err_d    = err_q;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    stallC   = 1'b0;
    ctrEn    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bad) begin
          err_d = 1'b1;
        end else if (accept) begin
          addr_d   = addr_in;
          wdata_d  = wdata_in;
          isRead_d = mem_read_en;
          stallC   = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        stallC = 1'b1;
        if (!mem_busy) begin
          mem_rd  = isRead_q;
          mem_wr  = ~isRead_q;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stallC = 1'b1;
        if (mem_done) begin
          if (isRead_q) rdata_d = mem_rdata;
          state_d = ST_DONE;
        end else begin
          ctrEn = 1'b1;
          if (expired) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stall follows the request combinationally but is forced low while in reset.
  assign stall_out   = rst & stallC;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign MemRead_out = rdata_q;
  assign err_out     = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus randomized
// accesses compared against a transaction-level timeline model.
module tb_mem_stage_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [15:0] addr_in;
  logic [15:0] wdata_in;
  logic [15:0] mem_rdata;
  logic        mem_busy;
  logic        mem_done;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] MemRead_out;
  logic        stall_out;
  logic        err_out;

  int assertCount = 0;
  int failCount   = 0;

  // Model state: last completed read data and the sticky error flag.
  logic [15:0] modelRdata;
  logic        modelErr;

  mem_stage_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .mem_rdata    (mem_rdata),
    .mem_busy     (mem_busy),
    .mem_done     (mem_done),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .MemRead_out  (MemRead_out),
    .stall_out    (stall_out),
    .err_out      (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed time limit reached, required end of test");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rd"},    32'(mem_rd),      0);
    checkOutput({tag, "_wr"},    32'(mem_wr),      0);
    checkOutput({tag, "_stall"}, 32'(stall_out),   0);
    checkOutput({tag, "_err"},   32'(err_out),     0);
    checkOutput({tag, "_addr"},  32'(mem_addr),    0);
    checkOutput({tag, "_wdata"}, 32'(mem_wdata),   0);
    checkOutput({tag, "_rdata"}, 32'(MemRead_out), 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    mem_read_en = 1'b0; mem_write_en = 1'b0; mem_done = 1'b0; mem_busy = 1'b0;
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    modelErr = 1'b0;
    modelRdata = 16'h0000;
  endtask

  // Non-memory cycles: nothing may stall or strobe; mem_done is noise.
  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_read_en = 1'b0; mem_write_en = 1'b0;
      addr_in = 16'($urandom); wdata_in = 16'($urandom); mem_rdata = 16'($urandom);
      mem_busy = 1'($urandom); mem_done = 1'($urandom);
      #1;
      checkOutput("idle_stall", 32'(stall_out),   0);
      checkOutput("idle_rd",    32'(mem_rd),      0);
      checkOutput("idle_wr",    32'(mem_wr),      0);
      checkOutput("idle_err",   32'(err_out),     32'(modelErr));
      checkOutput("idle_rdata", 32'(MemRead_out), 32'(modelRdata));
    end
    mem_done = 1'b0;
  endtask

  // Valid requests once the error flag is set: must be ignored entirely.
  task automatic applyIgnored(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_read_en = 1'b1; mem_write_en = 1'b0;
      addr_in = 16'h0040; wdata_in = 16'h7777; mem_busy = 1'b0; mem_done = 1'b0;
      #1;
      checkOutput("ign_stall", 32'(stall_out), 0);
      checkOutput("ign_rd",    32'(mem_rd),    0);
      checkOutput("ign_wr",    32'(mem_wr),    0);
      checkOutput("ign_err",   32'(err_out),   1);
    end
    mem_read_en = 1'b0;
  endtask

  // Misaligned or conflicting request: no stall, no strobe, error next cycle.
  task automatic applyBad(input logic rdEn, input logic wrEn, input logic [15:0] addr);
    @(negedge clk);
    mem_read_en = rdEn; mem_write_en = wrEn; addr_in = addr; mem_busy = 1'b0; mem_done = 1'b0;
    #1;
    checkOutput("bad_stall", 32'(stall_out), 0);
    checkOutput("bad_rd",    32'(mem_rd),    0);
    checkOutput("bad_wr",    32'(mem_wr),    0);
    checkOutput("bad_err0",  32'(err_out),   0);
    modelErr = 1'b1;
    applyIdle(1);
  endtask

  // One access. Timeline: request cycle, busyCycles stalled ISSUE cycles, the
  // strobe cycle, then mem_done 'latency' cycles after the strobe (or a timeout
  // after TIMEOUT wait cycles), and finally the DONE / post-timeout cycle.
  task automatic applyStimulus(input bit isRead, input logic [15:0] addr, input logic [15:0] wdata,
                               input int busyCycles, input int latency, input logic [15:0] rdata,
                               output int stallCycles, output int strobeCycles);
    bit timesOut;
    int strobeCycle;
    int doneCycle;
    int lastWait;
    int endCycle;
    timesOut     = (latency > TIMEOUT);
    strobeCycle  = busyCycles + 1;
    doneCycle    = strobeCycle + latency;
    lastWait     = timesOut ? strobeCycle + TIMEOUT : doneCycle;
    endCycle     = lastWait + 1;
    stallCycles  = 0;
    strobeCycles = 0;
    for (int k = 0; k <= endCycle; k++) begin
      @(negedge clk);
      mem_read_en = isRead; mem_write_en = ~isRead; addr_in = addr; wdata_in = wdata;
      if (k >= 1 && k <= busyCycles) mem_busy = 1'b1;
      else if (k == strobeCycle)     mem_busy = 1'b0;
      else                           mem_busy = 1'($urandom);
      if (k <= strobeCycle || k == endCycle)  mem_done = 1'($urandom);
      else if (!timesOut && k == doneCycle)   mem_done = 1'b1;
      else                                    mem_done = 1'b0;
      mem_rdata = (k == doneCycle) ? rdata : 16'($urandom);
      #1;
      if (k == endCycle) begin
        if (timesOut) modelErr = 1'b1;
        else if (isRead) modelRdata = rdata;
      end
      stallCycles  += int'(stall_out);
      strobeCycles += int'(mem_rd) + int'(mem_wr);
      checkOutput("acc_stall", 32'(stall_out),   32'(k < endCycle));
      checkOutput("acc_rd",    32'(mem_rd),      32'(isRead && k == strobeCycle));
      checkOutput("acc_wr",    32'(mem_wr),      32'(!isRead && k == strobeCycle));
      checkOutput("acc_err",   32'(err_out),     32'(modelErr));
      checkOutput("acc_rdata", 32'(MemRead_out), 32'(modelRdata));
      if (k >= 1 && (k <= lastWait || !timesOut)) begin
        checkOutput("acc_addr",  32'(mem_addr),  32'(addr));
        checkOutput("acc_wdata", 32'(mem_wdata), 32'(wdata));
      end
    end
    mem_done = 1'b0;
    mem_busy = 1'b0;
  endtask

  initial begin
    int nStall;
    int nStrobe;
    bit rIsRead;
    logic [15:0] rAddr;

    rst = 1'b0;
    mem_read_en = 1'b0; mem_write_en = 1'b0;
    addr_in = 16'h0; wdata_in = 16'h0; mem_rdata = 16'h0;
    mem_busy = 1'b0; mem_done = 1'b0;
    modelErr = 1'b0; modelRdata = 16'h0;

    #1;
    checkResetOutputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    applyIdle(2);

    $display("[TB] read 0x0010, latency 3");
    applyStimulus(1'b1, 16'h0010, 16'h0000, 0, 3, 16'hBEEF, nStall, nStrobe);
    checkOutput("read_stall_len",  32'(nStall),  5);
    checkOutput("read_strobe_cnt", 32'(nStrobe), 1);
    applyIdle(1);
    checkOutput("read_held", 32'(MemRead_out), 32'h0000BEEF);

    $display("[TB] write 0x1234 to 0x0020 with 2 busy cycles");
    applyStimulus(1'b0, 16'h0020, 16'h1234, 2, 2, 16'h0F0F, nStall, nStrobe);
    checkOutput("write_strobe_cnt", 32'(nStrobe), 1);
    applyIdle(1);
    checkOutput("write_keeps_rdata", 32'(MemRead_out), 32'h0000BEEF);

    $display("[TB] back-to-back reads");
    applyStimulus(1'b1, 16'h0002, 16'h0000, 0, 1, 16'hAAAA, nStall, nStrobe);
    checkOutput("b2b_first", 32'(MemRead_out), 32'h0000AAAA);
    applyStimulus(1'b1, 16'h0004, 16'h0000, 0, 2, 16'h5555, nStall, nStrobe);
    checkOutput("b2b_second", 32'(MemRead_out), 32'h00005555);

    $display("[TB] randomized accesses");
    for (int i = 0; i < 24; i++) begin
      rIsRead = 1'($urandom);
      rAddr   = 16'($urandom) & 16'hFFFE;
      applyStimulus(rIsRead, rAddr, 16'($urandom), int'($urandom_range(0, 2)),
                    int'($urandom_range(1, TIMEOUT)), 16'($urandom), nStall, nStrobe);
      checkOutput("rand_strobe_cnt", 32'(nStrobe), 1);
      applyIdle(int'($urandom_range(0, 2)));
    end

    $display("[TB] misaligned read");
    applyBad(1'b1, 1'b0, 16'h0011);
    applyIgnored(3);
    doReset();

    $display("[TB] conflicting read and write");
    applyBad(1'b1, 1'b1, 16'h0020);
    applyIgnored(2);
    doReset();

    $display("[TB] timeout");
    applyStimulus(1'b1, 16'h0030, 16'h0000, 0, TIMEOUT + 3, 16'h1111, nStall, nStrobe);
    checkOutput("timeout_stall_len", 32'(nStall), 32'(2 + TIMEOUT));
    applyIgnored(2);
    doReset();

    $display("[TB] reset during wait");
    @(negedge clk);
    mem_read_en = 1'b1; mem_write_en = 1'b0; addr_in = 16'h0008; wdata_in = 16'h9999;
    mem_busy = 1'b0; mem_done = 1'b0;
    #1;
    checkOutput("rw_req_stall", 32'(stall_out), 1);
    @(negedge clk);
    #1;
    checkOutput("rw_strobe", 32'(mem_rd), 1);
    @(negedge clk);
    #1;
    checkOutput("rw_wait_stall", 32'(stall_out), 1);
    checkOutput("rw_wait_addr",  32'(mem_addr),  32'h00000008);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkResetOutputs("rw_reset");
    @(negedge clk);
    rst = 1'b1;
    mem_read_en = 1'b0;
    @(negedge clk);
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    #1;
    checkOutput("rw_late_rd",    32'(mem_rd),    0);
    checkOutput("rw_late_stall", 32'(stall_out), 0);
    @(negedge clk);
    mem_done = 1'b0;
    #1;
    checkOutput("rw_late_rdata", 32'(MemRead_out), 0);
    checkOutput("rw_late_err",   32'(err_out),     0);

    applyStimulus(1'b1, 16'h0100, 16'h0000, 1, 2, 16'hC0DE, nStall, nStrobe);
    checkOutput("post_reset_read", 32'(MemRead_out), 32'h0000C0DE);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
